mem_req_master: RTL and testbench

//  Initiator side of the DPI RAM-control interface: accepts one load/store request at a time from the LSU

---
 rtl/mem_req_pkg.sv | 27 ++
 rtl/mem_lane_align.sv | 38 +++
 rtl/mem_req_master.sv | 150 +++++++++++++++
 tb/tb_mem_req_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared types and mask helpers for the LSU-to-RAM request master.
// The misalignment check is enabled with MEM_REQ_MISALIGN_CHECK_EN.
package mem_req_pkg;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_e;

   function automatic logic [7:0] byte_mask(size_e size, logic [2:0] off);
      logic [7:0] base;
      base = 8'h00;
      unique case (size)
         SZ_B: base = 8'h01;
         SZ_H: base = 8'h03;
         SZ_W: base = 8'h0F;
         SZ_D: base = 8'hFF;
      endcase
      return base << off;
   endfunction

   function automatic logic [63:0] expand_mask(logic [7:0] bm);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{bm[i]}};
      return m;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment: store shift and mask, load extract
// and sign/zero extension.
module mem_lane_align
   import mem_req_pkg::*;
(
   input  size_e       size,
   input  logic [2:0]  off,
   input  logic        uns,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata,
   output logic [63:0] wdata_sh,
   output logic [63:0] wmask,
   output logic [63:0] rdata_ext
);

   logic [63:0] raw;

   always_comb begin
      wdata_sh = wdata << {off, 3'b000};
      wmask    = expand_mask(byte_mask(size, off));
   end

   // Bytes shifted past lane 7 simply fall off the end.
   always_comb begin
      raw       = rdata >> {off, 3'b000};
      rdata_ext = raw;
      unique case (size)
         SZ_B: rdata_ext = uns ? {56'b0, raw[7:0]}
                               : {{56{raw[7]}}, raw[7:0]};
         SZ_H: rdata_ext = uns ? {48'b0, raw[15:0]}
                               : {{48{raw[15]}}, raw[15:0]};
         SZ_W: rdata_ext = uns ? {32'b0, raw[31:0]}
                               : {{32{raw[31]}}, raw[31:0]};
         SZ_D: rdata_ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_req_master.sv
// Single-outstanding load/store master toward the DPI RAM model.
// Define MEM_REQ_MISALIGN_CHECK_EN to reject misaligned requests.
module mem_req_master
   import mem_req_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int ADDR_W     = 64
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [63:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [63:0]       resp_rdata,
   output logic              resp_err,
   output logic [63:0]       ram_raddr,
   input  logic [63:0]       ram_rdata,
   output logic              ram_rflag,
   output logic [63:0]       ram_waddr,
   output logic [63:0]       ram_wdata,
   output logic [63:0]       ram_wmask,
   output logic              ram_wen
);

   localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   state_e      state;
   logic [CW-1:0] cnt;
   size_e       cap_size;
   logic [2:0]  cap_off;
   logic        cap_uns;
   size_e       sel_size;
   logic [2:0]  sel_off;
   logic        sel_uns;
   logic [63:0] al_wdata;
   logic [63:0] al_wmask;
   logic [63:0] al_rdata;
   logic        misalign;
   logic [63:0] aaddr;

   // Live request drives the aligner in IDLE, captured copy afterwards.
   always_comb begin
      sel_size = cap_size;
      sel_off  = cap_off;
      sel_uns  = cap_uns;
      if (state == IDLE) begin
         sel_size = size_e'(req_size);
         sel_off  = req_addr[2:0];
         sel_uns  = req_unsigned;
      end
   end

   assign aaddr = 64'({req_addr[ADDR_W-1:3], 3'b000});

`ifdef MEM_REQ_MISALIGN_CHECK_EN
   logic [2:0] amask;
   assign amask    = (3'b001 << req_size) - 3'b001;
   assign misalign = |(req_addr[2:0] & amask);
`else
   assign misalign = 1'b0;
`endif

   mem_lane_align u_align (
      .size      (sel_size),
      .off       (sel_off),
      .uns       (sel_uns),
      .wdata     (req_wdata),
      .rdata     (ram_rdata),
      .wdata_sh  (al_wdata),
      .wmask     (al_wmask),
      .rdata_ext (al_rdata)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         cap_size   <= SZ_B;
         cap_off    <= '0;
         cap_uns    <= 1'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         ram_raddr  <= '0;
         ram_rflag  <= 1'b0;
         ram_waddr  <= '0;
         ram_wdata  <= '0;
         ram_wmask  <= '0;
         ram_wen    <= 1'b0;
      end else begin
         ram_rflag <= 1'b0;
         ram_wen   <= 1'b0;
         unique case (state)
            IDLE: if (req_valid) begin
               cap_size  <= size_e'(req_size);
               cap_off   <= req_addr[2:0];
               cap_uns   <= req_unsigned;
               req_ready <= 1'b0;
               if (misalign) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else if (req_wen) begin
                  state     <= WR;
                  ram_wen   <= 1'b1;
                  ram_waddr <= aaddr;
                  ram_wdata <= al_wdata;
                  ram_wmask <= al_wmask;
               end else begin
                  state     <= RD_WAIT;
                  ram_rflag <= 1'b1;
                  ram_raddr <= aaddr;
                  cnt       <= CW'(RD_LATENCY - 1);
               end
            end
            RD_WAIT: begin
               if (cnt == '0) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= al_rdata;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WR: begin
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            RESP: if (resp_ready) begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_master.sv
// Directed and random checks of mem_req_master against a byte-level
// memory model.
module tb_mem_req_master;

   localparam int LAT = 3;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [63:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [63:0] ram_raddr;
   logic [63:0] ram_rdata;
   logic        ram_rflag;
   logic [63:0] ram_waddr;
   logic [63:0] ram_wdata;
   logic [63:0] ram_wmask;
   logic        ram_wen;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   mem_req_master #(.RD_LATENCY(LAT), .ADDR_W(64)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wen      (req_wen),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .ram_raddr    (ram_raddr),
      .ram_rdata    (ram_rdata),
      .ram_rflag    (ram_rflag),
      .ram_waddr    (ram_waddr),
      .ram_wdata    (ram_wdata),
      .ram_wmask    (ram_wmask),
      .ram_wen      (ram_wen)
   );

   // RAM: 32 words covering 0x80000000..0x800000FF
   logic [63:0] mem [32];
   assign ram_rdata = mem[ram_raddr[7:3]];
   always @(posedge clock)
      if (ram_wen)
         mem[ram_waddr[7:3]] <= (mem[ram_waddr[7:3]] & ~ram_wmask)
                              | (ram_wdata & ram_wmask);

   int          n_rflag = 0;
   int          n_wen = 0;
   logic [63:0] mon_raddr = '0;
   logic [63:0] mon_waddr = '0;
   logic [63:0] mon_wdata = '0;
   logic [63:0] mon_wmask = '0;
   always @(negedge clock) begin
      if (ram_rflag) begin
         n_rflag   <= n_rflag + 1;
         mon_raddr <= ram_raddr;
      end
      if (ram_wen) begin
         n_wen     <= n_wen + 1;
         mon_waddr <= ram_waddr;
         mon_wdata <= ram_wdata;
         mon_wmask <= ram_wmask;
      end
   end

   // Reference: flat byte memory
   logic [7:0] ref_mem [256];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit is_misaligned(input logic [63:0] a,
                                        input logic [1:0] sz);
`ifdef MEM_REQ_MISALIGN_CHECK_EN
      int n;
      n = 1 << sz;
      return (int'(a[2:0]) % n) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] a,
                                            input logic [1:0] sz,
                                            input logic u);
      logic [63:0] v;
      int n;
      n = 1 << sz;
      v = '0;
      for (int i = 0; i < n; i++)
         if (int'(a[2:0]) + i < 8) v[8*i +: 8] = ref_mem[int'(a[7:0]) + i];
      if (n < 8 && !u && v[8*n-1])
         v = v | ~((64'd1 << (8*n)) - 64'd1);
      return v;
   endfunction

   function automatic logic [63:0] ref_wmask(input logic [63:0] a,
                                             input logic [1:0] sz);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < (1 << sz); i++)
         if (int'(a[2:0]) + i < 8) m[8*(int'(a[2:0]) + i) +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic do_req(input logic wen, input logic [63:0] a,
                         input logic [1:0] sz, input logic u,
                         input logic [63:0] wd, input int hold);
      int lat;
      int r0, w0, exp_lat;
      bit bad;
      logic [63:0] exp_rd;
      bad     = is_misaligned(a, sz);
      exp_rd  = (wen || bad) ? 64'd0 : ref_load(a, sz, u);
      exp_lat = bad ? 1 : (wen ? 2 : LAT + 1);
      r0 = n_rflag;
      w0 = n_wen;
      @(negedge clock);
      req_valid = 1'b1;
      req_wen = wen;
      req_addr = a;
      req_size = sz;
      req_unsigned = u;
      req_wdata = wd;
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      req_addr = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_size = 2'($urandom);
      req_unsigned = 1'($urandom);
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      lat = 1;
      while (!resp_valid && lat < 40) begin
         @(posedge clock);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_err", 64'(resp_err), 64'(bad));
      chk("rflag_pulses", 64'(n_rflag - r0), 64'((!wen && !bad) ? 1 : 0));
      chk("wen_pulses", 64'(n_wen - w0), 64'((wen && !bad) ? 1 : 0));
      if (!wen && !bad)
         chk("ram_raddr", mon_raddr, {a[63:3], 3'b000});
      if (wen && !bad) begin
         chk("ram_waddr", mon_waddr, {a[63:3], 3'b000});
         chk("ram_wdata", mon_wdata, wd << (8 * int'(a[2:0])));
         chk("ram_wmask", mon_wmask, ref_wmask(a, sz));
         for (int i = 0; i < (1 << sz); i++)
            if (int'(a[2:0]) + i < 8)
               ref_mem[int'(a[7:0]) + i] = wd[8*i +: 8];
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clock);
         #1;
         chk("resp_hold_valid", 64'(resp_valid), 64'd1);
         chk("resp_hold_rdata", resp_rdata, exp_rd);
      end
      @(negedge clock);
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      resp_ready = 1'b0;
      chk("resp_done", 64'(resp_valid), 64'd0);
      chk("req_ready_back", 64'(req_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] a;
      logic [1:0]  sz;
      int r0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      #12;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_ram_wen", 64'(ram_wen), 64'd0);
      chk("rst_ram_rflag", 64'(ram_rflag), 64'd0);
      chk("rst_ram_wmask", ram_wmask, 64'd0);
      chk("rst_resp_rdata", resp_rdata, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("idle_req_ready", 64'(req_ready), 64'd1);
      chk("idle_ram_wen", 64'(ram_wen), 64'd0);
      chk("idle_ram_rflag", 64'(ram_rflag), 64'd0);

      // Known contents everywhere before any load
      for (int w = 0; w < 32; w++)
         do_req(1'b1, 64'h8000_0000 + 64'(w * 8), 2'd3, 1'b0,
                {$urandom, $urandom}, 0);

      do_req(1'b1, 64'h8000_0008, 2'd3, 1'b0, 64'h1122334455667788, 0);
      do_req(1'b1, 64'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_0000_00AB, 0);
      do_req(1'b0, 64'h8000_0008, 2'd3, 1'b0, 64'd0, 1);
      do_req(1'b1, 64'h8000_0006, 2'd1, 1'b0, 64'h0000_0000_0000_8001, 0);
      do_req(1'b0, 64'h8000_0006, 2'd1, 1'b0, 64'd0, 0);
      chk("load_h_signed", ref_load(64'h8000_0006, 2'd1, 1'b0),
          64'hFFFF_FFFF_FFFF_8001);
      do_req(1'b1, 64'h8000_0004, 2'd2, 1'b0, 64'h0000_0000_F234_5678, 0);
      do_req(1'b0, 64'h8000_0004, 2'd2, 1'b1, 64'd0, 5);
      do_req(1'b0, 64'h8000_0004, 2'd2, 1'b0, 64'd0, 2);
      do_req(1'b0, 64'h8000_0003, 2'd0, 1'b1, 64'd0, 0);
      do_req(1'b0, 64'h8000_0002, 2'd2, 1'b0, 64'd0, 0);
      do_req(1'b1, 64'h8000_0016, 2'd2, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 0);
      do_req(1'b0, 64'h8000_0015, 2'd3, 1'b0, 64'd0, 0);

      for (int k = 0; k < 40; k++) begin
         sz = 2'($urandom);
         a  = 64'h8000_0000 + 64'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 0) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
         do_req(1'($urandom), a, sz, 1'($urandom), {$urandom, $urandom},
                $urandom_range(0, 3));
      end

      // Async reset in the middle of a read
      r0 = n_rflag;
      @(negedge clock);
      req_valid = 1'b1;
      req_wen = 1'b0;
      req_addr = 64'h8000_0010;
      req_size = 2'd3;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_req_ready", 64'(req_ready), 64'd1);
      chk("arst_resp_valid", 64'(resp_valid), 64'd0);
      chk("arst_ram_raddr", ram_raddr, 64'd0);
      chk("arst_ram_rflag", 64'(ram_rflag), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (LAT + 2) @(posedge clock);
      #1;
      chk("arst_no_resp", 64'(resp_valid), 64'd0);
      chk("arst_rflag_once", 64'(n_rflag - r0), 64'd1);
      do_req(1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'd0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
